// File: rtl/kmeans_pkg.sv
// Shared sizing, FSM encoding and packed-field helpers for the k-means centroid update.
// CEN_UPDATE_ROUND_EN widens the divider dividend by one bit for round-to-nearest.
package kmeans_pkg;

  localparam int CEN_NUM  = 8;
  localparam int FEAT_NUM = 7;
  localparam int FEAT_W   = 13;
  localparam int ACC_W    = 24;
  localparam int CNT_W    = 16;

  localparam int IDX_W  = $clog2(CEN_NUM);
  localparam int FIDX_W = $clog2(FEAT_NUM);
  localparam int DATA_W = FEAT_NUM * FEAT_W;
  localparam int SUM_W  = FEAT_NUM * ACC_W;
  localparam int REM_W  = ACC_W + 1;

`ifdef CEN_UPDATE_ROUND_EN
  localparam int DVD_W = ACC_W + 1;
`else
  localparam int DVD_W = ACC_W;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    DIV  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } cu_state_t;

  function automatic logic [ACC_W-1:0] sum_field(input logic [SUM_W-1:0] v,
                                                 input logic [FIDX_W-1:0] f);
    return v[f*ACC_W +: ACC_W];
  endfunction

  function automatic logic [DATA_W-1:0] feat_set(input logic [DATA_W-1:0] v,
                                                 input logic [FIDX_W-1:0] f,
                                                 input logic [FEAT_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = v;
    r[f*FEAT_W +: FEAT_W] = x;
    return r;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done and the final quotient
// appear combinationally on the last step so back-to-back divides take DVD_W cycles each.
module seq_divider #(
  parameter int DVD_W = 24,
  parameter int DVS_W = 16,
  parameter int REM_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o,
  output logic [REM_W-1:0] remainder_o
);

  localparam int STEP_W = $clog2(DVD_W);

  logic [REM_W-1:0]  rem_q, rem_d;
  logic [DVD_W-1:0]  quo_q, quo_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;

  logic [REM_W-1:0]  src_rem;
  logic [DVD_W-1:0]  src_quo;
  logic [STEP_W-1:0] step;
  logic [REM_W:0]    rem_sh;
  logic [REM_W+1:0]  diff;
  logic              borrow;
  logic              active;
  logic              last;

  // divisor_i must stay stable for the whole divide; the first step uses dividend_i directly
  always_comb begin
    src_rem = start_i ? '0 : rem_q;
    src_quo = start_i ? dividend_i : quo_q;
    step    = start_i ? '0 : step_q;
    rem_sh  = {src_rem, src_quo[DVD_W-1]};
    diff    = {1'b0, rem_sh} - {{(REM_W+2-DVS_W){1'b0}}, divisor_i};
    borrow  = diff[REM_W+1];
    active  = start_i | busy_q;
    last    = active && (step == STEP_W'(DVD_W-1));

    rem_d  = rem_q;
    quo_d  = quo_q;
    step_d = step_q;
    busy_d = busy_q;
    if (active) begin
      rem_d  = borrow ? REM_W'(rem_sh) : REM_W'(diff);
      quo_d  = {src_quo[DVD_W-2:0], ~borrow};
      step_d = step + STEP_W'(1);
      busy_d = !last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = last;
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

endmodule

// File: rtl/centroid_update.sv
// k-means back end: divides each centroid's feature sums by its point count and writes it back.
// Optional macro CEN_UPDATE_ROUND_EN selects round-to-nearest instead of truncation.
module centroid_update
  import kmeans_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              acc_rd_en,
  output logic [IDX_W-1:0]  acc_rd_idx,
  input  logic [SUM_W-1:0]  acc_sum,
  input  logic [CNT_W-1:0]  acc_cnt,
  input  logic [DATA_W-1:0] old_cen,
  output logic              cen_wr_en,
  output logic [IDX_W-1:0]  cen_wr_idx,
  output logic [DATA_W-1:0] cen_wr_data
);

  cu_state_t         state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [FIDX_W-1:0] f_q, f_d;
  logic              conv_q, conv_d;
  logic              converged_q, converged_d;

  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] new_q, new_d;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DVD_W-1:0]  div_dividend;
  logic [DVD_W-1:0]  div_quo;

  function automatic logic [FEAT_W-1:0] sat_feat(input logic [DVD_W-1:0] q);
    if (|q[DVD_W-1:FEAT_W]) return {FEAT_W{1'b1}};
    return q[FEAT_W-1:0];
  endfunction

`ifdef CEN_UPDATE_ROUND_EN
  assign div_dividend = {1'b0, sum_field(sum_q, f_q)} + DVD_W'(cnt_q >> 1);
`else
  assign div_dividend = sum_field(sum_q, f_q);
`endif

  seq_divider #(
    .DVD_W(DVD_W),
    .DVS_W(CNT_W),
    .REM_W(REM_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (cnt_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o()
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    f_d         = f_q;
    conv_d      = conv_q;
    converged_d = converged_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    old_d       = old_q;
    new_d       = new_q;
    div_start   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        k_d         = '0;
        conv_d      = 1'b1;
        converged_d = 1'b0;
        state_d     = RD;
      end
      RD: state_d = CAP;
      CAP: begin
        sum_d = acc_sum;
        cnt_d = acc_cnt;
        old_d = old_cen;
        if (acc_cnt == '0) begin
          new_d   = old_cen;
          state_d = WR;
        end else begin
          f_d     = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        // a fresh divide launches the cycle after the previous one finishes
        div_start = !div_busy;
        if (div_done) begin
          new_d = feat_set(new_q, f_q, sat_feat(div_quo));
          if (f_q == FIDX_W'(FEAT_NUM-1)) state_d = WR;
          else                             f_d     = f_q + FIDX_W'(1);
        end
      end
      WR: begin
        conv_d = conv_q & (new_q == old_q);
        if (k_q == IDX_W'(CEN_NUM-1)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + IDX_W'(1);
          state_d = RD;
        end
      end
      DONE: begin
        converged_d = conv_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      f_q         <= '0;
      conv_q      <= 1'b0;
      converged_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      f_q         <= f_d;
      conv_q      <= conv_d;
      converged_q <= converged_d;
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
    cnt_q <= cnt_d;
    old_q <= old_d;
    new_q <= new_d;
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign converged   = (state_q == DONE) ? conv_q : converged_q;
  assign acc_rd_en   = (state_q == RD);
  assign acc_rd_idx  = (state_q == RD) ? k_q : '0;
  assign cen_wr_en   = (state_q == WR);
  assign cen_wr_idx  = (state_q == WR) ? k_q : '0;
  assign cen_wr_data = (state_q == WR) ? new_q : '0;

endmodule

// File: doc/centroid_update.md
Name: centroid_update

Overview:
- Back end of the k-means iteration. The classification block accumulates per-centroid feature sums and point counts; this block reads them back and produces the new centroids.
- Reads each centroid's sum vector and count, divides every feature sum by the count with an iterative divider, then writes the new centroid.
- Flags convergence when no centroid changed during the pass.

Parameters:
- CEN_NUM, 8, number of centroids.
- FEAT_NUM, 7, features per point.
- FEAT_W, 13, unsigned feature width; dataWidth = FEAT_NUM*FEAT_W = 91.
- ACC_W, 24, per-feature accumulator width.
- CNT_W, 16, point-count width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a pass; ignored unless in IDLE.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse at end of pass.
- converged  out  1  valid from done; held until the next accepted start.
- acc_rd_en  out  1  read strobe to the accumulator/centroid storage.
- acc_rd_idx  out  $clog2(CEN_NUM)  centroid index being read.
- acc_sum  in  FEAT_NUM*ACC_W  feature sums; feature f at [f*ACC_W +: ACC_W].
- acc_cnt  in  CNT_W  number of points assigned to the centroid.
- old_cen  in  FEAT_NUM*FEAT_W  current centroid; feature f at [f*FEAT_W +: FEAT_W].
- cen_wr_en  out  1  one-cycle write strobe.
- cen_wr_idx  out  $clog2(CEN_NUM)  centroid index written.
- cen_wr_data  out  FEAT_NUM*FEAT_W  new centroid, same packing as old_cen.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal k, f, quotient and remainder cleared. Reset asserted mid-pass aborts immediately, with no write and no done.
- Read interface: acc_sum, acc_cnt and old_cen are valid on the cycle after acc_rd_en (1-cycle registered read).
- FSM states:
  - IDLE: on start, set k=0, conv_r=1, clear converged, go to RD.
  - RD: acc_rd_en=1, acc_rd_idx=k for 1 cycle, then go to CAP.
  - CAP: latch sum, cnt and old. If cnt==0, new=old and go to WR. Otherwise set f=0 and go to DIV.
  - DIV: restoring divide of sum[f] by cnt, exactly ACC_W cycles per feature.
    - Quotient saturates to 2^FEAT_W-1 if it exceeds FEAT_W bits.
    - Store the quotient into new[f].
    - If f==FEAT_NUM-1 go to WR, else f+1 and stay in DIV.
  - WR: cen_wr_en=1, cen_wr_idx=k, cen_wr_data=new. conv_r &= (new==old). If k==CEN_NUM-1 go to DONE, else k+1 and go to RD.
  - DONE: done=1, converged=conv_r, go to IDLE.
- Latency:
  - Per centroid with cnt!=0: 3 + FEAT_NUM*ACC_W cycles, i.e. 171 with defaults.
  - Per centroid with cnt==0: 3 cycles.
  - Full pass: sum of per-centroid latencies + 1 cycle (DONE).
- busy is low in IDLE and high in all other states.
- start asserted while busy is ignored and has no side effects.
- acc_cnt==0 means an empty cluster. The old centroid is retained and written back, with no division; this is never a divide-by-zero.
- All arithmetic is unsigned. The remainder register is ACC_W+1 bits wide to hold the subtract borrow.

Optional Feature:
- Macro: CEN_UPDATE_ROUND_EN.
- Defined: the dividend is sum[f] + (cnt>>1), computed at ACC_W+1 bits, giving round-to-nearest. The divide then takes ACC_W+1 cycles per feature.
- Undefined: the quotient is truncated and the divide takes ACC_W cycles per feature.
- Latency figures in the test plan are for the undefined (truncating) build.

Decomposition:
- Package kmeans_pkg holds:
  - the parameters CEN_NUM, FEAT_NUM, FEAT_W, ACC_W and CNT_W;
  - the FSM state enum cu_state_t (IDLE, RD, CAP, DIV, WR, DONE);
  - the field-slice helper functions.
- Sub-module seq_divider: start/busy/done interface with dividend, divisor, quotient and remainder; one instance, reused for every feature.

Test Plan:
- Centroid 0 with sum = {10,20,30,40,50,60,70} and cnt=10; all others cnt=0 with old unchanged.
  - Expect the WR for idx0 to carry {1,2,3,4,5,6,7}.
  - Expect 8 writes in total, done 1 cycle after the last write, and converged=0.
- Every centroid's sums equal cnt*old (cnt=5).
  - Expect new==old on every write and converged=1.
- Sum 7 with cnt 2.
  - Without the macro the quotient is 3; with CEN_UPDATE_ROUND_EN it is 4.
- All counts 0.
  - Expect the pass to finish in 8*3+1 = 25 cycles after start, with old values echoed and converged=1.
- start pulsed again in mid-pass: no restart and the write sequence is unchanged. Then assert rst during DIV of centroid 3: outputs go to 0 at once and no further cen_wr_en or done appears.
- Sum 0xFFFFFF with cnt 1: the quotient saturates to 0x1FFF.
